// File: rtl/speed_cmd_ramp.sv
// speed_cmd_ramp: operator push-button front end for the motor PWM stage.
// Three raw buttons are synchronised and debounced; their press events move
// a 4-bit target speed, and hex_speed slews toward that target one step per
// ramp interval so the PWM stage never sees an abrupt duty-cycle jump.
module speed_cmd_ramp #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RAMP_CYCLES     = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   output logic [3:0] hex_speed,
   output logic [3:0] target,
   output logic       ramping
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PS_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_CYCLES - 1);
   localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

   // Button bit positions inside the packed vectors
   localparam int B_UP   = 0;
   localparam int B_DOWN = 1;
   localparam int B_STOP = 2;

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2
   } state_t;

   // Saturating one-step moves of a 4-bit speed value
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'd1;
   endfunction

   function automatic logic [3:0] sat_dec(input logic [3:0] v);
      return (v == 4'h0) ? 4'h0 : v - 4'd1;
   endfunction

   logic [2:0]      btn_raw_s;
   logic [2:0]      sync1_r;
   logic [2:0]      sync2_r;
   logic [2:0]      deb_r;
   logic [2:0]      deb_d_r;
   logic [DB_W-1:0] db_cnt_r [0:2];
   logic [2:0]      press_s;
   logic            stop_evt_s;
   logic            up_evt_s;
   logic            down_evt_s;

   logic [3:0]      target_r;
   logic [3:0]      hex_r;
   logic [PS_W-1:0] presc_r;
   logic            ramping_r;
   state_t          state_r;
   state_t          state_next_s;
   logic            presc_run_s;
   logic            step_up_s;
   logic            step_down_s;

   assign btn_raw_s = {btn_stop, btn_down, btn_up};

   // Two-flop synchroniser for the asynchronous button inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= btn_raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= {DB_W{1'b0}};
         end
         deb_r <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (db_cnt_r[i] == DB_LAST) begin
                  deb_r[i]    <= sync2_r[i];
                  db_cnt_r[i] <= {DB_W{1'b0}};
               end else begin
                  db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
               end
            end else begin
               db_cnt_r[i] <= {DB_W{1'b0}};
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_d_r <= 3'b000;
      end else begin
         deb_d_r <= deb_r;
      end
   end

   // Single-cycle press events; up and down together cancel, stop overrides both
   always_comb begin
      press_s    = deb_r & ~deb_d_r;
      stop_evt_s = press_s[B_STOP];
      up_evt_s   = press_s[B_UP] & ~press_s[B_DOWN];
      down_evt_s = press_s[B_DOWN] & ~press_s[B_UP];
   end

   // Requested speed: stop clears it, up/down move it one saturating step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target_r <= 4'h0;
      end else if (stop_evt_s) begin
         target_r <= 4'h0;
      end else if (up_evt_s) begin
         target_r <= sat_inc(target_r);
      end else if (down_evt_s) begin
         target_r <= sat_dec(target_r);
      end else begin
         target_r <= target_r;
      end
   end

   // Ramp FSM state register, with the ramping flag registered alongside it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_HOLD;
         ramping_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         ramping_r <= (state_next_s != ST_HOLD);
      end
   end

   // Ramp FSM next state from the registered target and output speed
   always_comb begin
      state_next_s = ST_HOLD;
      if (stop_evt_s) begin
         state_next_s = ST_HOLD;
      end else if (target_r > hex_r) begin
         state_next_s = ST_RAMP_UP;
      end else if (target_r < hex_r) begin
         state_next_s = ST_RAMP_DOWN;
      end else begin
         state_next_s = ST_HOLD;
      end
   end

   // Ramp FSM outputs: prescaler runs only while staying in the same ramp direction
   always_comb begin
      presc_run_s = 1'b0;
      step_up_s   = 1'b0;
      step_down_s = 1'b0;
      case (state_r)
         ST_RAMP_UP: begin
            presc_run_s = (state_next_s == ST_RAMP_UP);
            step_up_s   = presc_run_s && (presc_r == PS_LAST) && (target_r > hex_r);
         end
         ST_RAMP_DOWN: begin
            presc_run_s = (state_next_s == ST_RAMP_DOWN);
            step_down_s = presc_run_s && (presc_r == PS_LAST) && (target_r < hex_r);
         end
         default: begin
            presc_run_s = 1'b0;
            step_up_s   = 1'b0;
            step_down_s = 1'b0;
         end
      endcase
   end

   // Ramp prescaler: cleared in HOLD, on stop and on leaving or reversing a ramp
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r <= {PS_W{1'b0}};
      end else if (stop_evt_s || !presc_run_s) begin
         presc_r <= {PS_W{1'b0}};
      end else if (presc_r == PS_LAST) begin
         presc_r <= {PS_W{1'b0}};
      end else begin
         presc_r <= presc_r + PS_ONE;
      end
   end

   // Output speed: stop forces zero, otherwise one step toward target per interval
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hex_r <= 4'h0;
      end else if (stop_evt_s) begin
         hex_r <= 4'h0;
      end else if (step_up_s) begin
         hex_r <= sat_inc(hex_r);
      end else if (step_down_s) begin
         hex_r <= sat_dec(hex_r);
      end else begin
         hex_r <= hex_r;
      end
   end

   assign hex_speed = hex_r;
   assign target    = target_r;
   assign ramping   = ramping_r;

endmodule

// File: tb/tb_speed_cmd_ramp.sv
// Directed bench for speed_cmd_ramp with DEBOUNCE_CYCLES=4, RAMP_CYCLES=8.
// Inputs are driven and outputs sampled 1 ns after each rising edge; "En"
// in comments means the n-th rising edge after a scenario's first stimulus.
module tb_speed_cmd_ramp;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       btn_stop;
   logic [3:0] hex_speed;
   logic [3:0] target;
   logic       ramping;

   int checks = 0;
   int errors = 0;

   speed_cmd_ramp #(
      .DEBOUNCE_CYCLES(4),
      .RAMP_CYCLES    (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_stop (btn_stop),
      .hex_speed(hex_speed),
      .target   (target),
      .ramping  (ramping)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached limit without finishing", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stop press and release; leaves target=0, hex_speed=0, HOLD, all buttons quiet
   task automatic clear_all();
      btn_stop = 1'b1;
      tick(4);
      btn_stop = 1'b0;
      tick(8);
   endtask

   task automatic test_reset();
      rst = 1'b0; btn_up = 1'b1; btn_down = 1'b0; btn_stop = 1'b0;
      tick(3);
      checks++; if (hex_speed !== 4'h0) begin errors++; $display("FAIL reset_hex: got %0h expected %0h", hex_speed, 4'h0); end
      checks++; if (target !== 4'h0) begin errors++; $display("FAIL reset_target: got %0h expected %0h", target, 4'h0); end
      checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping: got %0b expected %0b", ramping, 1'b0); end
      rst = 1'b1;
      tick(6);
      checks++; if (target !== 4'h0) begin errors++; $display("FAIL reset_release_e6: got %0h expected %0h", target, 4'h0); end
      tick(1);
      checks++; if (target !== 4'h1) begin errors++; $display("FAIL reset_release_e7: got %0h expected %0h", target, 4'h1); end
      btn_up = 1'b0;
      tick(8);
      clear_all();
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 5; i++) begin
         btn_up = 1'b1; tick(2);
         btn_up = 1'b0; tick(2);
      end
      checks++; if (target !== 4'h0) begin errors++; $display("FAIL bounce_no_event: got %0h expected %0h", target, 4'h0); end
      btn_up = 1'b1;
      tick(6);
      checks++; if (target !== 4'h0) begin errors++; $display("FAIL bounce_e6: got %0h expected %0h", target, 4'h0); end
      tick(1);
      checks++; if (target !== 4'h1) begin errors++; $display("FAIL bounce_e7: got %0h expected %0h", target, 4'h1); end
      btn_up = 1'b0;
      tick(8);
      checks++; if (target !== 4'h1) begin errors++; $display("FAIL bounce_single: got %0h expected %0h", target, 4'h1); end
      clear_all();
   endtask

   // Presses every 8 edges: targets 1,2,3 at E7,E15,E23; steps at E16,E24,E32
   task automatic test_ramp();
      btn_up = 1'b1; tick(4);
      btn_up = 1'b0; tick(3);
      checks++; if (target !== 4'h1) begin errors++; $display("FAIL ramp_target1: got %0h expected %0h", target, 4'h1); end
      checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL ramp_ramping_e7: got %0b expected %0b", ramping, 1'b0); end
      tick(1);
      checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL ramp_ramping_e8: got %0b expected %0b", ramping, 1'b1); end
      btn_up = 1'b1; tick(4);
      btn_up = 1'b0; tick(3);
      checks++; if (hex_speed !== 4'h0 || target !== 4'h2) begin errors++; $display("FAIL ramp_e15: got hex %0h target %0h expected hex 0 target 2", hex_speed, target); end
      tick(1);
      checks++; if (hex_speed !== 4'h1) begin errors++; $display("FAIL ramp_step1: got %0h expected %0h", hex_speed, 4'h1); end
      btn_up = 1'b1; tick(4);
      btn_up = 1'b0; tick(3);
      checks++; if (hex_speed !== 4'h1 || target !== 4'h3) begin errors++; $display("FAIL ramp_e23: got hex %0h target %0h expected hex 1 target 3", hex_speed, target); end
      tick(1);
      checks++; if (hex_speed !== 4'h2) begin errors++; $display("FAIL ramp_step2: got %0h expected %0h", hex_speed, 4'h2); end
      tick(7);
      checks++; if (hex_speed !== 4'h2) begin errors++; $display("FAIL ramp_e31: got %0h expected %0h", hex_speed, 4'h2); end
      tick(1);
      checks++; if (hex_speed !== 4'h3 || ramping !== 1'b1) begin errors++; $display("FAIL ramp_step3: got hex %0h ramping %0b expected hex 3 ramping 1", hex_speed, ramping); end
      tick(1);
      checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL ramp_done: got %0b expected %0b", ramping, 1'b0); end
   endtask

   // Starts at hex=3 target=3 HOLD; up then down brings target back before a step
   task automatic test_reversal();
      btn_up = 1'b1; tick(4);
      btn_up = 1'b0; tick(2);
      btn_down = 1'b1; tick(1);
      checks++; if (target !== 4'h4) begin errors++; $display("FAIL rev_target4: got %0h expected %0h", target, 4'h4); end
      tick(3);
      btn_down = 1'b0; tick(3);
      checks++; if (target !== 4'h3 || hex_speed !== 4'h3 || ramping !== 1'b1) begin errors++; $display("FAIL rev_e13: got target %0h hex %0h ramping %0b expected 3 3 1", target, hex_speed, ramping); end
      tick(1);
      checks++; if (ramping !== 1'b0 || hex_speed !== 4'h3) begin errors++; $display("FAIL rev_hold: got ramping %0b hex %0h expected 0 3", ramping, hex_speed); end
      btn_down = 1'b1; tick(4);
      btn_down = 1'b0; tick(3);
      checks++; if (target !== 4'h2 || ramping !== 1'b0) begin errors++; $display("FAIL rev_e21: got target %0h ramping %0b expected 2 0", target, ramping); end
      tick(1);
      checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL rev_ramp_down: got %0b expected %0b", ramping, 1'b1); end
      tick(7);
      checks++; if (hex_speed !== 4'h3) begin errors++; $display("FAIL rev_e29: got %0h expected %0h", hex_speed, 4'h3); end
      tick(1);
      checks++; if (hex_speed !== 4'h2) begin errors++; $display("FAIL rev_step_down: got %0h expected %0h", hex_speed, 4'h2); end
      tick(10);
   endtask

   task automatic test_saturation();
      clear_all();
      btn_down = 1'b1; tick(4);
      btn_down = 1'b0; tick(4);
      checks++; if (target !== 4'h0 || ramping !== 1'b0) begin errors++; $display("FAIL sat_down_at_zero: got target %0h ramping %0b expected 0 0", target, ramping); end
      for (int i = 0; i < 17; i++) begin
         btn_up = 1'b1; tick(4);
         btn_up = 1'b0; tick(4);
         if (i == 14 || i == 15) begin
            checks++; if (target !== 4'hF) begin errors++; $display("FAIL sat_press_%0d: got %0h expected %0h", i + 1, target, 4'hF); end
         end
      end
      checks++; if (target !== 4'hF) begin errors++; $display("FAIL sat_target: got %0h expected %0h", target, 4'hF); end
      tick(4);
   endtask

   // Ten presses: hex=9 at E80 with next step due at E88, where stop+up land
   task automatic test_stop();
      clear_all();
      for (int i = 0; i < 10; i++) begin
         btn_up = 1'b1; tick(4);
         btn_up = 1'b0; tick(4);
      end
      checks++; if (hex_speed !== 4'h9 || target !== 4'hA) begin errors++; $display("FAIL stop_setup: got hex %0h target %0h expected 9 a", hex_speed, target); end
      tick(1);
      btn_up = 1'b1; btn_stop = 1'b1; tick(4);
      btn_up = 1'b0; btn_stop = 1'b0; tick(2);
      checks++; if (hex_speed !== 4'h9 || target !== 4'hA || ramping !== 1'b1) begin errors++; $display("FAIL stop_e87: got hex %0h target %0h ramping %0b expected 9 a 1", hex_speed, target, ramping); end
      tick(1);
      checks++; if (hex_speed !== 4'h0) begin errors++; $display("FAIL stop_hex: got %0h expected %0h", hex_speed, 4'h0); end
      checks++; if (target !== 4'h0) begin errors++; $display("FAIL stop_target: got %0h expected %0h", target, 4'h0); end
      checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL stop_ramping: got %0b expected %0b", ramping, 1'b0); end
      tick(8);
      checks++; if (hex_speed !== 4'h0 || target !== 4'h0) begin errors++; $display("FAIL stop_stays: got hex %0h target %0h expected 0 0", hex_speed, target); end
   endtask

   task automatic test_simultaneous();
      clear_all();
      btn_up = 1'b1; tick(4);
      btn_up = 1'b0; tick(4);
      checks++; if (target !== 4'h1) begin errors++; $display("FAIL simul_setup: got %0h expected %0h", target, 4'h1); end
      btn_up = 1'b1; btn_down = 1'b1; tick(4);
      btn_up = 1'b0; btn_down = 1'b0; tick(4);
      checks++; if (target !== 4'h1 || hex_speed !== 4'h1) begin errors++; $display("FAIL simul_ignored: got target %0h hex %0h expected 1 1", target, hex_speed); end
      tick(8);
      checks++; if (target !== 4'h1 || ramping !== 1'b0) begin errors++; $display("FAIL simul_settled: got target %0h ramping %0b expected 1 0", target, ramping); end
   endtask

   // From hex=1 target=1: three presses give hex=3 target=4 at E24, then async reset
   task automatic test_reset_mid_ramp();
      for (int i = 0; i < 3; i++) begin
         btn_up = 1'b1; tick(4);
         btn_up = 1'b0; tick(4);
      end
      checks++; if (hex_speed !== 4'h3 || target !== 4'h4 || ramping !== 1'b1) begin errors++; $display("FAIL midrst_setup: got hex %0h target %0h ramping %0b expected 3 4 1", hex_speed, target, ramping); end
      rst = 1'b0;
      #1;
      checks++; if (hex_speed !== 4'h0 || target !== 4'h0 || ramping !== 1'b0) begin errors++; $display("FAIL midrst_async: got hex %0h target %0h ramping %0b expected 0 0 0", hex_speed, target, ramping); end
      tick(2);
      rst = 1'b1;
      tick(10);
      checks++; if (hex_speed !== 4'h0 || target !== 4'h0 || ramping !== 1'b0) begin errors++; $display("FAIL midrst_after: got hex %0h target %0h ramping %0b expected 0 0 0", hex_speed, target, ramping); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_ramp();
      test_reversal();
      test_saturation();
      test_stop();
      test_simultaneous();
      test_reset_mid_ramp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
